// File: rtl/abro_pkg.sv
// Shared constants and helpers for the ABRO input conditioning front end.
// Pure compile-time content; no latency, no backpressure.
package abro_pkg;

  localparam int unsigned ABRO_DEBOUNCE_DEFAULT = 4;

  // Counter must hold DEBOUNCE_CYCLES-1; one bit is the floor for N=1 and N=2.
  function automatic int unsigned abro_cnt_w(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/abro_debounce_channel.sv
// One channel: 2-flop synchroniser, debounce counter, registered rise pulse.
// Latency DEBOUNCE_CYCLES+2 edges from a held raw change; no backpressure.
module abro_debounce_channel
  import abro_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = ABRO_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out
);

  localparam int unsigned CNT_W = abro_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = raw_in;
    s2_d    = s1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = cnt_q;
    // Any sample agreeing with the output restarts the window, so bounce never accumulates.
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s2_q;
      rise_d  = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;

endmodule

// File: rtl/abro_input_conditioner.sv
// Conditions raw A/B inputs into clean levels and rise pulses for the ABRO FSM.
// Latency DEBOUNCE_CYCLES+2 edges per channel; no backpressure, channels independent.
module abro_input_conditioner
  import abro_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = ABRO_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_out,
  output logic b_out,
  output logic a_rise,
  output logic b_rise
);

  abro_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk      (clk),
    .resetn   (resetn),
    .raw_in   (a_raw),
    .level_out(a_out),
    .rise_out (a_rise)
  );

  abro_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk      (clk),
    .resetn   (resetn),
    .raw_in   (b_raw),
    .level_out(b_out),
    .rise_out (b_rise)
  );

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Scoreboard bench for abro_input_conditioner at DEBOUNCE_CYCLES = 4, 1 and 16.
// Expected output events are queued with their edge number; a monitor pops them.
module tb_abro_input_conditioner;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;

  logic a4 = 1'b0, b4 = 1'b0, a1 = 1'b0, b1 = 1'b0, a16 = 1'b0, b16 = 1'b0;
  logic d4_ao, d4_bo, d4_ar, d4_br;
  logic d1_ao, d1_bo, d1_ar, d1_br;
  logic d16_ao, d16_bo, d16_ar, d16_br;

  logic [5:0] lvl_v, rise_v, prev;

  typedef struct {
    int   ch;
    int   cyc;
    logic lvl;
    logic rise;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = clk_run ? ~clk : clk;
  always @(posedge clk) cyc++;

  abro_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .resetn(resetn), .a_raw(a4), .b_raw(b4),
    .a_out(d4_ao), .b_out(d4_bo), .a_rise(d4_ar), .b_rise(d4_br)
  );

  abro_input_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .resetn(resetn), .a_raw(a1), .b_raw(b1),
    .a_out(d1_ao), .b_out(d1_bo), .a_rise(d1_ar), .b_rise(d1_br)
  );

  abro_input_conditioner #(.DEBOUNCE_CYCLES(16)) dut16 (
    .clk(clk), .resetn(resetn), .a_raw(a16), .b_raw(b16),
    .a_out(d16_ao), .b_out(d16_bo), .a_rise(d16_ar), .b_rise(d16_br)
  );

  // Channel index: 0 d4.a, 1 d4.b, 2 d1.a, 3 d1.b, 4 d16.a, 5 d16.b
  assign lvl_v  = {d16_bo, d16_ao, d1_bo, d1_ao, d4_bo, d4_ao};
  assign rise_v = {d16_br, d16_ar, d1_br, d1_ar, d4_br, d4_ar};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int ch, input int at, input logic l, input logic r);
    evt_t e;
    e.ch = ch;
    e.cyc = at;
    e.lvl = l;
    e.rise = r;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, want);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("%s_lvl_ch%0d", tag, c), int'(lvl_v[c]), 0);
      chk($sformatf("%s_rise_ch%0d", tag, c), int'(rise_v[c]), 0);
    end
  endtask

  bit pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    prev = '0;
    fork
      forever begin
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].ch == c) idx = i;
          if (resetn) begin
            if (lvl_v[c] != prev[c] || rise_v[c]) begin
              n_checks++;
              if (idx < 0) begin
                $display("FAIL unexpected_evt ch%0d: cyc=%0d lvl=%b rise=%b, want no event",
                         c, cyc, lvl_v[c], rise_v[c]);
              end else begin
                if (exp_q[idx].cyc == cyc && exp_q[idx].lvl == lvl_v[c] &&
                    exp_q[idx].rise == rise_v[c])
                  n_pass++;
                else
                  $display("FAIL evt ch%0d: got cyc=%0d lvl=%b rise=%b, want cyc=%0d lvl=%b rise=%b",
                           c, cyc, lvl_v[c], rise_v[c], exp_q[idx].cyc, exp_q[idx].lvl,
                           exp_q[idx].rise);
                exp_q.delete(idx);
              end
            end else if (idx >= 0 && exp_q[idx].cyc < cyc) begin
              n_checks++;
              $display("FAIL missed_evt ch%0d: no event by cyc=%0d, want lvl=%b at cyc=%0d",
                       c, cyc, exp_q[idx].lvl, exp_q[idx].cyc);
              exp_q.delete(idx);
            end
          end
          prev[c] = lvl_v[c];
        end
      end
    join_none

    // Reset held with every raw input high: nothing may leak through.
    {a4, b4, a1, b1, a16, b16} = '1;
    clk_run = 1'b1;
    tick(3);
    @(negedge clk);
    chk_all_zero("reset_hold");
    {a4, b4, a1, b1, a16, b16} = '0;
    tick(2);
    resetn = 1'b1;
    tick(3);

    // Clean rising edge on A, N=4.
    a4 = 1'b1; expect_evt(0, cyc + 6, 1'b1, 1'b1);
    tick(12);

    // Three-sample glitch on B is rejected, four samples pass, then a clean fall.
    b4 = 1'b1; tick(3); b4 = 1'b0; tick(10);
    b4 = 1'b1; expect_evt(1, cyc + 6, 1'b1, 1'b1);
    tick(4);
    b4 = 1'b0; expect_evt(1, cyc + 6, 1'b0, 1'b0);
    tick(12);

    // Bounce on A: only the final run of four ones qualifies.
    a4 = 1'b0; expect_evt(0, cyc + 6, 1'b0, 1'b0);
    tick(10);
    for (int i = 0; i < 9; i++) begin
      a4 = pat[i];
      if (i == 5) expect_evt(0, cyc + 6, 1'b1, 1'b1);
      tick(1);
    end
    tick(10);

    // Simultaneous rise and fall on both channels.
    a4 = 1'b0; expect_evt(0, cyc + 6, 1'b0, 1'b0);
    tick(10);
    a4 = 1'b1; b4 = 1'b1;
    expect_evt(0, cyc + 6, 1'b1, 1'b1); expect_evt(1, cyc + 6, 1'b1, 1'b1);
    tick(10);
    a4 = 1'b0; b4 = 1'b0;
    expect_evt(0, cyc + 6, 1'b0, 1'b0); expect_evt(1, cyc + 6, 1'b0, 1'b0);
    tick(10);

    // N=1 and N=16 latency, a single-cycle pulse at N=1, a 15-cycle pulse at N=16.
    a1 = 1'b1; expect_evt(2, cyc + 3, 1'b1, 1'b1);
    a16 = 1'b1; expect_evt(4, cyc + 18, 1'b1, 1'b1);
    tick(22);
    b1 = 1'b1; expect_evt(3, cyc + 3, 1'b1, 1'b1); expect_evt(3, cyc + 4, 1'b0, 1'b0);
    tick(1);
    b1 = 1'b0;
    tick(6);
    b16 = 1'b1; tick(15); b16 = 1'b0;
    tick(22);

    // Reset mid-count with the clock stopped; raw A held high through release.
    a4 = 1'b1; expect_evt(0, cyc + 6, 1'b1, 1'b1);
    tick(8);
    a4 = 1'b0;
    tick(3);
    @(negedge clk);
    clk_run = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk_all_zero("reset_async");
    a4 = 1'b1;
    clk_run = 1'b1;
    tick(3);
    resetn = 1'b1;
    expect_evt(0, cyc + 6, 1'b1, 1'b1);
    expect_evt(2, cyc + 3, 1'b1, 1'b1);
    expect_evt(4, cyc + 18, 1'b1, 1'b1);
    tick(25);

    foreach (exp_q[i])
      $display("FAIL pending_evt ch%0d: never seen, want lvl=%b at cyc=%0d",
               exp_q[i].ch, exp_q[i].lvl, exp_q[i].cyc);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
